bus_arbiter_rr: RTL and testbench

- Three-master bus arbiter and transaction sequencer for the shared system bus. Masters: CPU (0), VGA (1), DMA (2).
- Grants one master at a time using round-robin priority and muxes its request onto the bus.
- Takes a one-hot chipselect from the external address decoder and sequences start / programmable wait states / acknowledge per slave.
- Replaces fixed-priority arbitration so VGA refill and DMA cannot be starved by CPU traffic.

---
 rtl/bus_arbiter_rr.sv | 157 +++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// Three-master round-robin bus arbiter with per-chipselect programmable wait states.
// Optional macro ARB_LOCK_EN adds cpu_lock for atomic back-to-back CPU transactions.
module bus_arbiter_rr #(
    parameter logic [39:0] WAIT_TABLE = 40'h0000000000,
    parameter int          NUM_CS     = 10
) (
    input  logic               clock,
    input  logic               reset,
`ifdef ARB_LOCK_EN
    input  logic               cpu_lock,
`endif
    input  logic [2:0]         m_read,
    input  logic [2:0]         m_write,
    input  logic [95:0]        m_addr,
    input  logic [11:0]        m_be,
    input  logic [95:0]        m_wdata,
    output logic [2:0]         m_wait,
    input  logic [NUM_CS-1:0]  cs_in,
    output logic [31:0]        address,
    output logic               read,
    output logic               write,
    output logic [3:0]         be,
    output logic [31:0]        writedata,
    output logic [NUM_CS-1:0]  chipselect,
    output logic               start,
    output logic [2:0]         grant,
    output logic               bus_error
);

    typedef enum logic [1:0] {IDLE, START, WAIT, ACK} state_t;

    state_t      state_q;
    logic [2:0]  grant_q;
    logic [1:0]  last_q;
    logic [3:0]  count_q;
    logic        err_q;

    logic [2:0]  wr_eff;
    logic [2:0]  req;
    logic        gnt_req;
    logic [1:0]  pick;
    logic [3:0]  cs_nib;

    // First requester searching last+1, last+2, last (mod 3).
    function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [1:0] id;
        logic [1:0] c2;
        logic       found;
        int         c;
        id    = last;
        found = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            c  = (int'(last) + k) % 3;
            c2 = 2'(c);
            if (!found && r[c2]) begin
                id    = c2;
                found = 1'b1;
            end
        end
        return id;
    endfunction

    // Descending scan so the lowest set chipselect bit selects the nibble.
    function automatic logic [3:0] cs_wait(input logic [NUM_CS-1:0] cs);
        logic [3:0] n;
        n = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (cs[i]) n = WAIT_TABLE[4*i +: 4];
        end
        return n;
    endfunction

    // VGA never writes, so its write bit is masked off.
    assign wr_eff  = m_write & 3'b101;
    assign req     = m_read | wr_eff;
    assign gnt_req = |(grant_q & req);
    assign pick    = rr_pick(req, last_q);
    assign cs_nib  = cs_wait(cs_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 3'b000;
            last_q  <= 2'd2;
            count_q <= 4'd0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req) begin
                        grant_q <= 3'b001 << pick;
                        last_q  <= pick;
                        err_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (!gnt_req) begin
                        grant_q <= 3'b000;
                        state_q <= IDLE;
                    end else if (cs_in == '0) begin
                        err_q   <= 1'b1;
                        state_q <= ACK;
                    end else begin
                        count_q <= cs_nib;
                        state_q <= (cs_nib == 4'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (!gnt_req) begin
                        grant_q <= 3'b000;
                        state_q <= IDLE;
                    end else if (count_q == 4'd1) begin
                        state_q <= ACK;
                    end else begin
                        count_q <= count_q - 4'd1;
                    end
                end
                ACK: begin
                    err_q <= 1'b0;
`ifdef ARB_LOCK_EN
                    if (grant_q[0] && cpu_lock) begin
                        state_q <= START;
                    end else begin
                        grant_q <= 3'b000;
                        state_q <= IDLE;
                    end
`else
                    grant_q <= 3'b000;
                    state_q <= IDLE;
`endif
                end
                default: begin
                    grant_q <= 3'b000;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Grant is zero outside a transaction, so the AND-OR mux drives 0 when idle.
    assign address   = ({32{grant_q[0]}} & m_addr[31:0])  | ({32{grant_q[1]}} & m_addr[63:32])
                     | ({32{grant_q[2]}} & m_addr[95:64]);
    assign writedata = ({32{grant_q[0]}} & m_wdata[31:0]) | ({32{grant_q[1]}} & m_wdata[63:32])
                     | ({32{grant_q[2]}} & m_wdata[95:64]);
    assign be        = ({4{grant_q[0]}} & m_be[3:0]) | ({4{grant_q[1]}} & m_be[7:4])
                     | ({4{grant_q[2]}} & m_be[11:8]);
    assign read      = |(grant_q & m_read);
    assign write     = |(grant_q & wr_eff);

    assign grant      = grant_q;
    assign start      = (state_q == START);
    assign m_wait     = ~(grant_q & {3{state_q == ACK}});
    assign bus_error  = (state_q == ACK) && err_q;
    assign chipselect = (state_q != IDLE) ? cs_in : '0;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Randomized bench for bus_arbiter_rr against a transaction-timeline reference model.
module tb_bus_arbiter_rr;

    localparam logic [39:0] WT = 40'h2105020413;

    logic        clock = 1'b0;
    logic        reset;
`ifdef ARB_LOCK_EN
    logic        cpu_lock;
`endif
    logic [2:0]  m_read, m_write, m_wait, grant;
    logic [95:0] m_addr, m_wdata;
    logic [11:0] m_be;
    logic [9:0]  cs_in, chipselect;
    logic [31:0] address, writedata;
    logic        read, write, start, bus_error;
    logic [3:0]  be;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    bus_arbiter_rr #(.WAIT_TABLE(WT), .NUM_CS(10)) dut (
        .clock(clock), .reset(reset),
`ifdef ARB_LOCK_EN
        .cpu_lock(cpu_lock),
`endif
        .m_read(m_read), .m_write(m_write), .m_addr(m_addr), .m_be(m_be),
        .m_wdata(m_wdata), .m_wait(m_wait), .cs_in(cs_in), .address(address),
        .read(read), .write(write), .be(be), .writedata(writedata),
        .chipselect(chipselect), .start(start), .grant(grant), .bus_error(bus_error)
    );

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a transaction is busy from its START cycle (age 0) until its ACK at age==total.
    bit          busy;
    int          owner, age, total, last_id;
    bit          err_m;
    bit   [2:0]  ack_prev;
    logic [39:0] wt_v;

    bit   [2:0]  active;
    bit   [2:0]  is_rd;
    int          resets_done;

    function automatic int wait_of(input logic [9:0] cs);
        for (int i = 0; i < 10; i++)
            if (cs[i]) return int'(wt_v[4*i +: 4]);
        return 0;
    endfunction

    task automatic model_reset();
        busy     = 0;
        last_id  = 2;
        age      = 0;
        total    = 0;
        err_m    = 0;
        ack_prev = 3'b000;
    endtask

    task automatic check_outputs();
        logic [2:0] eg;
        bit         ack;
        eg  = busy ? (3'b001 << owner) : 3'b000;
        ack = busy && age > 0 && age == total;
        check_eq("grant", grant, eg);
        check_eq("start", start, busy && age == 0);
        check_eq("m_wait", m_wait, 3'b111 & ~(ack ? eg : 3'b000));
        check_eq("bus_error", bus_error, ack && err_m);
        check_eq("chipselect", chipselect, busy ? cs_in : 10'h0);
        check_eq("address", address, busy ? m_addr[32*owner +: 32] : 32'h0);
        check_eq("writedata", writedata, busy ? m_wdata[32*owner +: 32] : 32'h0);
        check_eq("be", be, busy ? m_be[4*owner +: 4] : 4'h0);
        check_eq("read", read, busy ? m_read[owner] : 1'b0);
        check_eq("write", write, busy ? m_write[owner] : 1'b0);
        ack_prev = ack ? eg : 3'b000;
    endtask

    task automatic step_model();
        logic [2:0] req;
        bit         lock;
        req  = m_read | m_write;
        lock = 0;
`ifdef ARB_LOCK_EN
        lock = cpu_lock;
`endif
        if (!busy) begin
            if (|req) begin
                for (int k = 3; k >= 1; k--)
                    if (req[(last_id + k) % 3]) owner = (last_id + k) % 3;
                busy    = 1;
                age     = 0;
                total   = 0;
                last_id = owner;
            end
        end else if (age == 0) begin
            if (!req[owner]) busy = 0;
            else begin
                err_m = (cs_in == 10'h0);
                total = err_m ? 1 : 1 + wait_of(cs_in);
                age   = 1;
            end
        end else if (age < total) begin
            if (!req[owner]) busy = 0;
            else age++;
        end else begin
            if (owner == 0 && lock) begin
                age   = 0;
                total = 0;
                err_m = 0;
            end else busy = 0;
        end
    endtask

    task automatic drive_inputs();
        int r;
        for (int i = 0; i < 3; i++) begin
            if (ack_prev[i]) active[i] = 0;
            if (active[i] && $urandom_range(0, 49) == 0) active[i] = 0;
            else if (!active[i] && $urandom_range(0, 2) == 0) begin
                active[i] = 1;
                is_rd[i]  = (i == 1) ? 1'b1 : 1'($urandom_range(0, 1));
                m_addr[32*i +: 32]  = $urandom;
                m_wdata[32*i +: 32] = $urandom;
                m_be[4*i +: 4]      = 4'($urandom);
            end
            m_read[i]  = active[i] && is_rd[i];
            m_write[i] = active[i] && !is_rd[i];
        end
        r = $urandom_range(0, 9);
        if (r == 0) cs_in = 10'h0;
        else if (r == 1) cs_in = 10'($urandom);
        else cs_in = 10'h1 << $urandom_range(0, 9);
`ifdef ARB_LOCK_EN
        cpu_lock = 1'($urandom_range(0, 1));
`endif
    endtask

    initial begin
        wt_v        = WT;
        reset       = 1'b1;
        m_read      = '0;
        m_write     = '0;
        m_addr      = '0;
        m_wdata     = '0;
        m_be        = '0;
        cs_in       = '0;
        active      = '0;
        is_rd       = '0;
        resets_done = 0;
`ifdef ARB_LOCK_EN
        cpu_lock    = 1'b0;
`endif
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check_eq("rst_grant", grant, 3'b000);
        check_eq("rst_m_wait", m_wait, 3'b111);
        check_eq("rst_start", start, 1'b0);
        check_eq("rst_chipselect", chipselect, 10'h0);
        check_eq("rst_bus_error", bus_error, 1'b0);
        check_eq("rst_address", address, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clock);
            drive_inputs();
            #1;
            check_outputs();
            if (busy && age >= 1 && age < total && resets_done < 5 &&
                $urandom_range(0, 9) == 0) begin
                resets_done++;
                reset = 1'b1;
                #1;
                check_eq("async_rst_grant", grant, 3'b000);
                check_eq("async_rst_m_wait", m_wait, 3'b111);
                check_eq("async_rst_start", start, 1'b0);
                check_eq("async_rst_chipselect", chipselect, 10'h0);
                model_reset();
                @(posedge clock);
                #1;
                reset = 1'b0;
            end else begin
                step_model();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
